// File: rtl/tap_tempo_ctrl.sv
// tap_tempo_ctrl
//   Averages the last AVG_DEPTH tap periods and converts the average into BPM
//   with a shared bit-serial restoring divider. Periods arriving while the
//   divider is busy are held in a one-deep pending slot, where the newest wins.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for a period (pending slot first, then the strobe)
//   UPDATE | shift the period into the history, update sum, load divider
//   DIVIDE | one quotient bit per cycle, DIV_W cycles
//   DONE   | bpm_o holds the clamped result, bpm_valid_o high for 1 cycle
//
// Ports
//   clk_i           system clock
//   rst_i           asynchronous active-high reset
//   btn_per_i       measured tap period in time-pulse ticks
//   btn_per_valid_i one-cycle strobe qualifying btn_per_i
//   bpm_o           last computed BPM, held between updates
//   bpm_valid_o     one-cycle strobe, bpm_o updated this cycle
//   busy_o          high while the FSM is not IDLE
//   fill_o          number of valid history entries
module tap_tempo_ctrl #(
  parameter int TP_CYCLE  = 5120,
  parameter int PER_W     = 24,
  parameter int AVG_DEPTH = 4,
  parameter int BPM_MAX   = 250,
  parameter int BPM_W     = 9
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [PER_W-1:0]                 btn_per_i,
  input  logic                             btn_per_valid_i,
  output logic [BPM_W-1:0]                 bpm_o,
  output logic                             bpm_valid_o,
  output logic                             busy_o,
  output logic [$clog2(AVG_DEPTH+1)-1:0]   fill_o
);

  localparam int FW    = $clog2(AVG_DEPTH + 1);
  localparam int DIV_W = PER_W + $clog2(AVG_DEPTH) + 1;
  localparam int CW    = $clog2(DIV_W);

  localparam logic [PER_W-1:0] PER_MAX  = PER_W'(64'd60_000_000_000 / 64'(TP_CYCLE));
  localparam logic [PER_W-1:0] PER_MIN  = PER_W'(PER_MAX / PER_W'(BPM_MAX));
  localparam logic [FW-1:0]    FILL_MAX = FW'(AVG_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_DIVIDE, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [PER_W-1:0]   r_hist [AVG_DEPTH];
  logic [FW-1:0]      r_fill;
  logic [DIV_W-1:0]   r_sum;
  logic [PER_W-1:0]   r_new_per;
  logic               r_pend_vld;
  logic [PER_W-1:0]   r_pend_per;
  logic [DIV_W-1:0]   r_rem;
  logic [DIV_W-1:0]   r_quo;
  logic [DIV_W-1:0]   r_div;
  logic [CW-1:0]      r_cnt;
  logic [BPM_W-1:0]   r_bpm;

  logic               w_take;
  logic [PER_W-1:0]   w_per;
  logic               w_timeout;
  logic               w_reject;
  logic               w_good;
  logic [FW-1:0]      w_fill_new;
  logic [DIV_W-1:0]   w_evict;
  logic [DIV_W-1:0]   w_sum_new;
  logic [DIV_W:0]     w_rem_sh;
  logic [DIV_W:0]     w_diff;
  logic [DIV_W-1:0]   w_rem_next;
  logic [DIV_W-1:0]   w_quo_next;
  logic [BPM_W-1:0]   w_bpm_clamp;

  // The pending slot always takes priority over a fresh strobe in IDLE.
  assign w_take    = (r_state == S_IDLE) && (r_pend_vld || btn_per_valid_i);
  assign w_per     = r_pend_vld ? r_pend_per : btn_per_i;
  assign w_timeout = (w_per >= PER_MAX);
  assign w_reject  = (w_per < PER_MIN);
  assign w_good    = !w_timeout && !w_reject;

  assign w_fill_new = (r_fill == FILL_MAX) ? r_fill : r_fill + FW'(1);
  assign w_evict    = (r_fill == FILL_MAX) ? DIV_W'(r_hist[AVG_DEPTH-1]) : '0;
  assign w_sum_new  = r_sum - w_evict + DIV_W'(r_new_per);

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  assign w_rem_sh   = {r_rem, r_quo[DIV_W-1]};
  assign w_diff     = w_rem_sh - {1'b0, r_div};
  assign w_rem_next = w_diff[DIV_W] ? w_rem_sh[DIV_W-1:0] : w_diff[DIV_W-1:0];
  assign w_quo_next = {r_quo[DIV_W-2:0], ~w_diff[DIV_W]};
  assign w_bpm_clamp = (w_quo_next > DIV_W'(BPM_MAX)) ? BPM_W'(BPM_MAX)
                                                      : w_quo_next[BPM_W-1:0];

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_take && w_good) w_state_nxt = S_UPDATE;
      S_UPDATE: w_state_nxt = S_DIVIDE;
      S_DIVIDE: if (r_cnt == '0) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs, decoded from registered state only
  always_comb begin
    busy_o      = (r_state != S_IDLE);
    bpm_valid_o = (r_state == S_DONE);
  end

  assign bpm_o  = r_bpm;
  assign fill_o = r_fill;

  // Datapath
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < AVG_DEPTH; k++) r_hist[k] <= '0;
      r_fill     <= '0;
      r_sum      <= '0;
      r_new_per  <= '0;
      r_pend_vld <= 1'b0;
      r_pend_per <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_div      <= '0;
      r_cnt      <= '0;
      r_bpm      <= '0;
    end else begin
      // In IDLE a strobe is consumed directly unless the slot is being
      // serviced this cycle, in which case the strobe refills the slot.
      if (r_state == S_IDLE) begin
        r_pend_vld <= r_pend_vld && btn_per_valid_i;
        if (r_pend_vld && btn_per_valid_i) r_pend_per <= btn_per_i;
      end else if (btn_per_valid_i) begin
        r_pend_vld <= 1'b1;
        r_pend_per <= btn_per_i;
      end

      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            if (w_timeout) begin
              for (int k = 0; k < AVG_DEPTH; k++) r_hist[k] <= '0;
              r_fill <= '0;
              r_sum  <= '0;
            end else if (w_good) begin
              r_new_per <= w_per;
            end
          end
        end
        S_UPDATE: begin
          for (int k = AVG_DEPTH-1; k > 0; k--) r_hist[k] <= r_hist[k-1];
          r_hist[0] <= r_new_per;
          r_fill    <= w_fill_new;
          r_sum     <= w_sum_new;
          r_div     <= w_sum_new;
          r_quo     <= DIV_W'(PER_MAX) * DIV_W'(w_fill_new);
          r_rem     <= '0;
          r_cnt     <= CW'(DIV_W - 1);
        end
        S_DIVIDE: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt - CW'(1);
          // The last step's quotient is final; publish it for the DONE cycle.
          if (r_cnt == '0) r_bpm <= w_bpm_clamp;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tap_tempo_ctrl.sv
module tb_tap_tempo_ctrl;

  localparam int PER_W = 24;
  localparam int BPM_W = 9;
  localparam int FW    = 3;
  localparam int DIV_W = 27;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic [PER_W-1:0]  btn_per_i = '0;
  logic              btn_per_valid_i = 1'b0;
  logic [BPM_W-1:0]  bpm_o;
  logic              bpm_valid_o;
  logic              busy_o;
  logic [FW-1:0]     fill_o;

  tap_tempo_ctrl dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .btn_per_i       (btn_per_i),
    .btn_per_valid_i (btn_per_valid_i),
    .bpm_o           (bpm_o),
    .bpm_valid_o     (bpm_valid_o),
    .busy_o          (busy_o),
    .fill_o          (fill_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int bpm;
    int fill;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_pulse = 0;
  logic prev_valid = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard side: every strobe must match the oldest expected result.
  always @(negedge clk_i) begin
    if (bpm_valid_o) begin
      exp_t e;
      n_pulse++;
      check("valid_not_consecutive", int'(prev_valid), 0);
      check("bpm_le_max", int'(bpm_o <= 9'd250), 1);
      n_tests++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_strobe: got bpm %0d expected no strobe", bpm_o);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("bpm", int'(bpm_o), e.bpm);
        check("fill", int'(fill_o), e.fill);
      end
    end
    prev_valid = bpm_valid_o;
  end

  task automatic tap(input int per);
    @(negedge clk_i);
    btn_per_i       = PER_W'(per);
    btn_per_valid_i = 1'b1;
    @(negedge clk_i);
    btn_per_valid_i = 1'b0;
  endtask

  task automatic push(input int bpm, input int fill);
    exp_t e;
    e.bpm  = bpm;
    e.fill = fill;
    sb.push_back(e);
  endtask

  task automatic wait_sb(input string tag);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge clk_i);
      k++;
    end
    check(tag, sb.size(), 0);
    repeat (2) @(negedge clk_i);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int all_busy;
    int pulses0;

    // Reset state
    repeat (3) @(negedge clk_i);
    check("rst_bpm", int'(bpm_o), 0);
    check("rst_valid", int'(bpm_valid_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_fill", int'(fill_o), 0);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // Single period, with latency and busy tracking
    push(120, 1);
    tap(97_656);
    lat = 0;
    all_busy = 1;
    while (!bpm_valid_o && lat < 200) begin
      if (!busy_o) all_busy = 0;
      @(negedge clk_i);
      lat++;
    end
    check("latency", lat, DIV_W + 1);
    check("busy_during", all_busy, 1);
    wait_sb("drain_single");
    check("busy_after", int'(busy_o), 0);

    // Second period averages with the first
    push(80, 2);
    tap(195_312);
    wait_sb("drain_two");

    // Timeout clears history and holds bpm
    tap(11_718_750);
    repeat (4) @(negedge clk_i);
    check("timeout_fill", int'(fill_o), 0);
    check("timeout_bpm_hold", int'(bpm_o), 80);

    // Five identical periods: fill saturates, oldest evicted
    for (int i = 1; i <= 5; i++) begin
      push(60, (i > 4) ? 4 : i);
      tap(195_312);
      wait_sb("drain_sat");
    end
    check("sum_after_evict", int'(dut.r_sum), 781_248);

    // Boundaries: PER_MIN gives BPM_MAX, below PER_MIN rejected
    tap(11_718_750);
    repeat (4) @(negedge clk_i);
    check("clear_fill", int'(fill_o), 0);
    check("clear_bpm_hold", int'(bpm_o), 60);
    push(250, 1);
    tap(46_875);
    wait_sb("drain_min");
    pulses0 = n_pulse;
    tap(40_000);
    repeat (6) @(negedge clk_i);
    check("reject_fill", int'(fill_o), 1);
    check("reject_bpm", int'(bpm_o), 250);
    check("reject_no_strobe", n_pulse - pulses0, 0);
    check("reject_busy", int'(busy_o), 0);
    tap(11_718_750);
    repeat (4) @(negedge clk_i);
    check("timeout2_fill", int'(fill_o), 0);
    check("timeout2_bpm", int'(bpm_o), 250);

    // Three strobes during one division: only the newest is serviced
    pulses0 = n_pulse;
    push(120, 1);
    push(96, 2);
    tap(97_656);
    tap(97_656);
    tap(195_312);
    tap(146_484);
    wait_sb("drain_pending");
    repeat (40) @(negedge clk_i);
    check("pending_pulses", n_pulse - pulses0, 2);
    check("pending_fill", int'(fill_o), 2);

    // Reset in the middle of a division
    pulses0 = n_pulse;
    tap(195_312);
    repeat (10) @(negedge clk_i);
    check("pre_rst_busy", int'(busy_o), 1);
    rst_i = 1'b1;
    #1;
    check("midrst_bpm", int'(bpm_o), 0);
    check("midrst_valid", int'(bpm_valid_o), 0);
    check("midrst_busy", int'(busy_o), 0);
    check("midrst_fill", int'(fill_o), 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (40) @(negedge clk_i);
    check("midrst_no_strobe", n_pulse - pulses0, 0);
    push(120, 1);
    tap(97_656);
    wait_sb("drain_after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
